player_position_ctrl: RTL and testbench
=======================================

# player_position_ctrl

Downstream consumer of the movement FSM's registered direction code. On every movement tick it computes the neighbouring grid cell in the current direction and rejects moves outside the grid. For in-bounds targets it queries the maze wall memory over a req/ack handshake, then commits the player's grid position. Outputs are the player cell coordinates for the renderer and per-step `moved` / `blocked` status pulses.

## Interface
- `GRID_W`, 20, grid columns (x range 0..GRID_W-1)
- `GRID_H`, 15, grid rows (y range 0..GRID_H-1)
- `X_W`, 5, x coordinate width
- `Y_W`, 4, y coordinate width
- `START_X`, 1, x after reset
- `START_Y`, 1, y after reset
- `STEP_CYCLES`, 5000000, clock cycles per movement tick (10 steps/s at 50 MHz)

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  movement enabled
- `dir`  in  3  direction code: 000 still, 001 up, 010 left, 011 down, 100 right; 101–111 are treated as still
- `wall_req`  out  1  wall lookup request
- `wall_x`  out  X_W  lookup cell x
- `wall_y`  out  Y_W  lookup cell y
- `wall_ack`  in  1  lookup complete
- `wall_is_wall`  in  1  1 if the looked-up cell is a wall; valid only while `wall_ack`=1
- `pos_x`  out  X_W  player cell x
- `pos_y`  out  Y_W  player cell y
- `moved`  out  1  one-cycle pulse: position changed
- `blocked`  out  1  one-cycle pulse: move rejected (grid edge or wall)

## Operation
- Tick counter:
  - Counts 0..STEP_CYCLES-1 while `enable`=1, then wraps to 0.
  - The cycle in which it equals STEP_CYCLES-1 is a tick.
  - `enable`=0 clears it to 0 and holds it there.
- FSM states: IDLE, CALC, REQ.
- IDLE:
  - On a tick with `enable`=1, latch `dir` and go to CALC.
  - Ticks seen in CALC or REQ are dropped; the counter keeps running.
- CALC computes the target cell, then:
  - Still or invalid direction: go to IDLE, no pulse.
  - Up with y=0, down with y=GRID_H-1, left with x=0, right with x=GRID_W-1: go to IDLE and assert `blocked` next cycle.
  - Otherwise: register the target onto `wall_x`/`wall_y` and go to REQ.
- REQ:
  - `wall_req`=1 for the whole state; `wall_x`/`wall_y` stay stable.
  - Waits indefinitely for `wall_ack`.
  - On `wall_ack`=1 with `wall_is_wall`=0: commit `pos_x`/`pos_y` to the target, pulse `moved`, go to IDLE.
  - On `wall_ack`=1 with `wall_is_wall`=1: pulse `blocked`, go to IDLE.
- `enable` falling during CALC or REQ does not abort; the in-flight step completes.
- `dir` changes after latching have no effect until the next tick.
- `moved` and `blocked` are never high together.

## Timing
- Reset values: `pos_x`=START_X, `pos_y`=START_Y. `wall_req`, `moved`, `blocked`, `wall_x`, `wall_y` and the counter are 0. State is IDLE.
- Reset mid-lookup drops `wall_req` immediately (asynchronously). Any late `wall_ack` is then ignored because the FSM is in IDLE.
- Tick in cycle T:
  - CALC in T+1.
  - `wall_req`=1 from T+2.
  - `wall_ack` sampled in cycle A ≥ T+2: position and pulse visible in A+1, `wall_req`=0 in A+1.
- Zero-wait memory (ack in T+2): `moved` in T+3.
- Edge block: `blocked` in T+2, no request issued.
- Minimum step period is STEP_CYCLES; STEP_CYCLES ≥ 4 is required.
- All outputs are registered.

## Structure
- Shared package `player_pkg`:
  - Direction constants `DIR_STILL`, `DIR_UP`, `DIR_LEFT`, `DIR_DOWN`, `DIR_RIGHT` (also used by the movement FSM).
  - `GRID_W`/`GRID_H` defaults.
- Sub-module `step_timer`: parameterised tick counter with enable-clear, producing a one-cycle `tick`.
- FSM and position registers live in the top module.

## Test plan
All scenarios use STEP_CYCLES=4.
1. Reset: `reset` pulse mid-cycle → pos=(1,1), all pulses 0, `wall_req`=0 with no clock edge required.
2. Right, zero-wait ack, `wall_is_wall`=0 → `wall_x`/`wall_y`=(2,1) with `wall_req` in T+2; pos=(2,1) and `moved`=1 in T+3; next step gives (3,1).
3. Up from (1,0) → `blocked` in T+2, no `wall_req`, pos unchanged.
4. Left from (1,1), ack after 5 wait cycles, `wall_is_wall`=1 → `wall_req` held 5+ cycles with stable (0,1) address, then `blocked`, pos stays (1,1). A tick during the wait produces no extra request.
5. `dir`=111 and `dir`=000 → no request, no pulses. `enable`=0 for 10 cycles → no ticks; on re-enable the first tick arrives 4 cycles later.
6. Assert `reset` while `wall_req`=1 → `wall_req` drops immediately; a late `wall_ack` afterwards causes no position change.

Source files
------------

// File: rtl/player_pkg.sv
// Shared definitions for the player movement path: direction codes used by the
// movement FSM and this controller, default grid size, controller state type.
package player_pkg;

  localparam int GRID_W = 20;
  localparam int GRID_H = 15;

  localparam logic [2:0] DIR_STILL = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_LEFT  = 3'b010;
  localparam logic [2:0] DIR_DOWN  = 3'b011;
  localparam logic [2:0] DIR_RIGHT = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    REQ
  } pos_state_t;

endpackage

// File: rtl/player_position_ctrl_if.sv
// Wall-memory lookup handshake: the controller is master, the maze memory is slave.
interface player_position_ctrl_if #(
  parameter int X_W = 5,
  parameter int Y_W = 4
);

  logic           wall_req;
  logic [X_W-1:0] wall_x;
  logic [Y_W-1:0] wall_y;
  logic           wall_ack;
  logic           wall_is_wall;

  modport master (
    output wall_req, wall_x, wall_y,
    input  wall_ack, wall_is_wall
  );

  modport slave (
    input  wall_req, wall_x, wall_y,
    output wall_ack, wall_is_wall
  );

endinterface

// File: rtl/step_timer.sv
// Free-running movement tick counter; enable=0 clears and holds it at zero.
module step_timer #(
  parameter int STEP_CYCLES = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/player_position_ctrl.sv
// Player grid position controller: on each movement tick, edge-checks the
// neighbouring cell, looks it up in wall memory, and commits or rejects the step.
module player_position_ctrl #(
  parameter int GRID_W      = player_pkg::GRID_W,
  parameter int GRID_H      = player_pkg::GRID_H,
  parameter int X_W         = 5,
  parameter int Y_W         = 4,
  parameter int START_X     = 1,
  parameter int START_Y     = 1,
  parameter int STEP_CYCLES = 5000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2:0]            dir,
  player_position_ctrl_if.master mem,
  output logic [X_W-1:0]        pos_x,
  output logic [Y_W-1:0]        pos_y,
  output logic                  moved,
  output logic                  blocked
);

  import player_pkg::*;

  logic           tick;
  pos_state_t     state;
  logic [2:0]     dir_q;
  logic [X_W-1:0] tgt_x;
  logic [Y_W-1:0] tgt_y;
  logic           at_edge;
  logic           still;

  step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    tgt_x   = pos_x;
    tgt_y   = pos_y;
    at_edge = 1'b0;
    still   = 1'b0;
    case (dir_q)
      DIR_UP: begin
        at_edge = (pos_y == '0);
        tgt_y   = pos_y - 1'b1;
      end
      DIR_LEFT: begin
        at_edge = (pos_x == '0);
        tgt_x   = pos_x - 1'b1;
      end
      DIR_DOWN: begin
        at_edge = (pos_y == Y_W'(GRID_H - 1));
        tgt_y   = pos_y + 1'b1;
      end
      DIR_RIGHT: begin
        at_edge = (pos_x == X_W'(GRID_W - 1));
        tgt_x   = pos_x + 1'b1;
      end
      default: still = 1'b1;
    endcase
  end

  // Ticks arriving in CALC or REQ are ignored; enable only gates new steps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      dir_q        <= DIR_STILL;
      pos_x        <= X_W'(START_X);
      pos_y        <= Y_W'(START_Y);
      mem.wall_req <= 1'b0;
      mem.wall_x   <= '0;
      mem.wall_y   <= '0;
      moved        <= 1'b0;
      blocked      <= 1'b0;
    end else begin
      moved   <= 1'b0;
      blocked <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            dir_q <= dir;
            state <= CALC;
          end
        end
        CALC: begin
          state <= IDLE;
          if (!still) begin
            if (at_edge) begin
              blocked <= 1'b1;
            end else begin
              mem.wall_x   <= tgt_x;
              mem.wall_y   <= tgt_y;
              mem.wall_req <= 1'b1;
              state        <= REQ;
            end
          end
        end
        REQ: begin
          if (mem.wall_ack) begin
            mem.wall_req <= 1'b0;
            state        <= IDLE;
            if (mem.wall_is_wall) begin
              blocked <= 1'b1;
            end else begin
              pos_x <= mem.wall_x;
              pos_y <= mem.wall_y;
              moved <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_position_ctrl.sv
// Self-checking bench for player_position_ctrl: directed scenarios plus a random
// phase, compared every cycle against a step-timeline reference model.
module tb_player_position_ctrl;

  localparam int STEP   = 4;
  localparam int GW     = 20;
  localparam int GH     = 15;
  localparam int X_W    = 5;
  localparam int Y_W    = 4;

  logic           clock;
  logic           reset;
  logic           enable;
  logic [2:0]     dir;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic           moved;
  logic           blocked;

  player_position_ctrl_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  player_position_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .X_W(X_W), .Y_W(Y_W),
    .START_X(1), .START_Y(1), .STEP_CYCLES(STEP)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .dir     (dir),
    .mem     (bus),
    .pos_x   (pos_x),
    .pos_y   (pos_y),
    .moved   (moved),
    .blocked (blocked)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: a step is planned as a timeline at the tick that starts it.
  int cyc = 0;
  int run_len = 0;
  int free_c = 0;
  int req_start = 0, ack_c = 0, pulse_c = -1;
  bit plan_req = 0, pulse_move = 0, plan_wall = 0;
  int tgt_x = 0, tgt_y = 0;
  int m_x = 1, m_y = 1, m_wx = 0, m_wy = 0;

  // Stimulus controls: -1 means randomise.
  int f_dir = 0, f_wait = 0, f_wall = 0;
  int en_pct = 100;
  bit en_off = 0;
  int late_ack = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit req_expected();
    return plan_req && (cyc >= req_start) && (cyc <= ack_c);
  endfunction

  task automatic check_outputs();
    if (pulse_c == cyc && pulse_move) begin
      m_x = tgt_x;
      m_y = tgt_y;
    end
    if (plan_req && cyc == req_start) begin
      m_wx = tgt_x;
      m_wy = tgt_y;
    end
    check("wall_req", bus.wall_req, req_expected());
    check("moved",    moved,   pulse_c == cyc && pulse_move);
    check("blocked",  blocked, pulse_c == cyc && !pulse_move);
    check("pos_x",    pos_x,   m_x);
    check("pos_y",    pos_y,   m_y);
    check("wall_x",   bus.wall_x, m_wx);
    check("wall_y",   bus.wall_y, m_wy);
  endtask

  task automatic plan_step(input int d);
    int tx, ty, w;
    bit edge_hit, is_still, wall;
    tx = m_x; ty = m_y; edge_hit = 0; is_still = 0;
    case (d)
      1: begin edge_hit = (m_y == 0);      ty = m_y - 1; end
      2: begin edge_hit = (m_x == 0);      tx = m_x - 1; end
      3: begin edge_hit = (m_y == GH - 1); ty = m_y + 1; end
      4: begin edge_hit = (m_x == GW - 1); tx = m_x + 1; end
      default: is_still = 1;
    endcase
    plan_req = 0;
    pulse_c  = -1;
    if (is_still) begin
      free_c = cyc + 2;
    end else if (edge_hit) begin
      pulse_c    = cyc + 2;
      pulse_move = 0;
      free_c     = cyc + 2;
    end else begin
      w    = (f_wait >= 0) ? f_wait : int'($urandom_range(6));
      wall = (f_wall >= 0) ? f_wall[0] : ($urandom_range(99) < 30);
      tgt_x      = tx;
      tgt_y      = ty;
      plan_req   = 1;
      plan_wall  = wall;
      req_start  = cyc + 2;
      ack_c      = cyc + 2 + w;
      pulse_c    = ack_c + 1;
      pulse_move = !wall;
      free_c     = pulse_c;
    end
  endtask

  task automatic drive_inputs();
    bit en, tk;
    int d;
    en = en_off ? 1'b0 : ($urandom_range(99) < en_pct);
    d  = (f_dir >= 0) ? f_dir : int'($urandom_range(7));
    enable = en;
    dir    = 3'(d);
    if (late_ack > 0) begin
      bus.wall_ack     = 1'b1;
      bus.wall_is_wall = 1'b0;
      late_ack--;
    end else if (plan_req && cyc == ack_c) begin
      bus.wall_ack     = 1'b1;
      bus.wall_is_wall = plan_wall;
    end else begin
      bus.wall_ack     = 1'b0;
      bus.wall_is_wall = 1'($urandom_range(1));
    end
    tk = 0;
    if (en) begin
      run_len++;
      tk = (run_len % STEP == 0);
    end else begin
      run_len = 0;
    end
    if (tk && cyc >= free_c) plan_step(d);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    cyc++;
    check_outputs();
    drive_inputs();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_until_pos(input int x, input int y, input int limit);
    int n = 0;
    while ((m_x != x || m_y != y) && n < limit) begin
      cycle();
      n++;
    end
    check("reach_pos_x", pos_x, x);
    check("reach_pos_y", pos_y, y);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic apply_reset();
    #2;
    bus.wall_ack = 1'b0;
    reset = 1'b1;
    #1;
    check("async_wall_req", bus.wall_req, 0);
    check("async_moved",    moved, 0);
    check("async_blocked",  blocked, 0);
    check("async_pos_x",    pos_x, 1);
    check("async_pos_y",    pos_y, 1);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc += 3;
    plan_req = 0;
    pulse_c  = -1;
    free_c   = 0;
    run_len  = 0;
    m_x = 1; m_y = 1; m_wx = 0; m_wy = 0;
    check_outputs();
    drive_inputs();
  endtask

  initial begin
    int n;
    reset = 1'b0;
    enable = 1'b0;
    dir = 3'b000;
    bus.wall_ack = 1'b0;
    bus.wall_is_wall = 1'b0;

    apply_reset();

    // Right with zero-wait open memory, twice; then walk back to (1,1).
    f_dir = 4; f_wait = 0; f_wall = 0;
    run_until_pos(3, 1, 30);
    f_dir = 2;
    run_until_pos(1, 1, 30);

    // Up to the top row, then keep pushing into the edge.
    f_dir = 1;
    run_until_pos(1, 0, 30);
    run(12);
    f_dir = 3;
    run_until_pos(1, 1, 30);

    // Slow memory reporting a wall on the left.
    f_dir = 2; f_wait = 5; f_wall = 1;
    run(12);
    f_dir = 0;
    run(8);

    // Invalid and still directions, then an enable gap.
    f_dir = 7;
    run(12);
    f_dir = 0;
    run(8);
    en_off = 1;
    run(10);
    en_off = 0;
    f_dir = 4; f_wait = 0; f_wall = 0;
    run(6);
    f_dir = 2;
    run_until_pos(1, 1, 30);

    // Reset in the middle of a lookup, followed by a stale ack.
    f_dir = 4; f_wait = 8; f_wall = 0;
    n = 0;
    while (!req_expected() && n < 40) begin
      cycle();
      n++;
    end
    check("req_before_reset", bus.wall_req, 1);
    en_off = 1;
    late_ack = 2;
    apply_reset();
    run(6);
    en_off = 0;
    f_dir = 0; f_wait = 0;
    run(8);

    // Reach the right and bottom edges, then the left edge.
    f_dir = 4; f_wait = 0; f_wall = 0;
    run_until_pos(GW - 1, 1, 200);
    run(10);
    f_dir = 3;
    run_until_pos(GW - 1, GH - 1, 200);
    run(10);
    f_dir = 2;
    run_until_pos(0, GH - 1, 200);
    run(10);

    // Random directions, waits, walls and enable drops.
    f_dir = -1; f_wait = -1; f_wall = -1; en_pct = 90;
    run(800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
